// File: rtl/waveform_plotter.sv
// Oscilloscope-style plotter: captures one screen of audio samples, then on a full
// buffer clears the framebuffer and draws one vertical span per column joining samples.
module waveform_plotter #(
  parameter int DATA_W = 16,
  parameter int NCOLS  = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  input  logic                     frame_start,
  output logic [9:0]               x,
  output logic [8:0]               y,
  output logic                     pixel_color,
  output logic                     pixel_write,
  output logic                     busy
);

  localparam int         AW       = $clog2(NCOLS);
  localparam logic [9:0] LAST_COL = 10'(NCOLS - 1);
  localparam logic [9:0] FULL_CNT = 10'(NCOLS);
  localparam logic [8:0] LAST_ROW = 9'd479;

  typedef enum logic [2:0] {S_WAIT, S_CLEAR, S_READ, S_LOAD, S_DRAW} state_t;

  state_t state_q, state_d;
  logic [9:0] wr_ptr_q, wr_ptr_d;
  logic       armed_q, armed_d;
  logic [9:0] col_q, col_d;
  logic [8:0] prev_q, prev_d;
  logic [8:0] cur_q, cur_d;
  logic [8:0] hi_q, hi_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       color_q, color_d;
  logic       cap_en;
  logic       full;

  logic signed [7:0] mem_q [NCOLS];
  logic signed [7:0] rdata_q;
  logic [8:0]        row_ld, prev_ld, lo_ld, hi_ld;
  logic              unused_lsbs;

  // Mid-screen row 240 minus the sample; 9-bit wraparound keeps this exact for -128..127.
  function automatic logic [8:0] row_of(input logic signed [7:0] v);
    return 9'd240 - {v[7], v};
  endfunction

  assign unused_lsbs = ^sample;
  assign full        = (wr_ptr_q == FULL_CNT);
  assign row_ld      = row_of(rdata_q);
  assign prev_ld     = (col_q == '0) ? row_ld : prev_q;
  assign lo_ld       = (prev_ld < row_ld) ? prev_ld : row_ld;
  assign hi_ld       = (prev_ld < row_ld) ? row_ld : prev_ld;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    armed_d  = armed_q;
    col_d    = col_q;
    prev_d   = prev_q;
    cur_d    = cur_q;
    hi_d     = hi_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    cap_en   = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (armed_q && !full && sample_valid && !rst) begin
          cap_en   = 1'b1;
          wr_ptr_d = wr_ptr_q + 10'd1;
        end
        if (frame_start && full) begin
          state_d = S_CLEAR;
          armed_d = 1'b0;
          x_d     = '0;
          y_d     = '0;
          color_d = 1'b0;
        end
      end
      S_CLEAR: begin
        // The final clear write leaves x/y parked at the last pixel until the first draw.
        if (x_q == LAST_COL) begin
          if (y_q == LAST_ROW) begin
            state_d = S_READ;
            col_d   = '0;
          end else begin
            x_d = '0;
            y_d = y_q + 9'd1;
          end
        end else begin
          x_d = x_q + 10'd1;
        end
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        cur_d   = row_ld;
        hi_d    = hi_ld;
        x_d     = col_q;
        y_d     = lo_ld;
        color_d = 1'b1;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (y_q == hi_q) begin
          prev_d = cur_q;
          if (col_q == LAST_COL) begin
            state_d  = S_WAIT;
            wr_ptr_d = '0;
            armed_d  = 1'b1;
          end else begin
            col_d   = col_q + 10'd1;
            state_d = S_READ;
          end
        end else begin
          y_d = y_q + 9'd1;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WAIT;
      wr_ptr_q <= '0;
      armed_q  <= 1'b1;
      col_q    <= '0;
      prev_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      color_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      armed_q  <= armed_d;
      col_q    <= col_d;
      prev_q   <= prev_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_q <= cur_d;
    hi_q  <= hi_d;
  end

  // Sample store: only the top byte of each sample is kept; read data lands in LOAD.
  always_ff @(posedge clk) begin
    if (cap_en) mem_q[wr_ptr_q[AW-1:0]] <= sample[DATA_W-1 -: 8];
    if (state_q == S_READ) rdata_q <= mem_q[col_q[AW-1:0]];
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_color = color_q;
  assign pixel_write = (state_q == S_CLEAR) || (state_q == S_DRAW);
  assign busy        = (state_q != S_WAIT);

endmodule

// File: tb/tb_waveform_plotter.sv
// Bench for waveform_plotter with a narrow screen (NCOLS=8) so whole frames stay short;
// every cycle of each frame is compared against a stream built from the plotting rules.
module tb_waveform_plotter;

  localparam int DATA_W = 16;
  localparam int NCOLS  = 8;
  localparam int NROWS  = 480;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     sample_valid;
  logic                     frame_start;
  logic signed [DATA_W-1:0] sample;
  logic [9:0]               x;
  logic [8:0]               y;
  logic                     pixel_color;
  logic                     pixel_write;
  logic                     busy;

  always #5 clk = ~clk;

  waveform_plotter #(.DATA_W(DATA_W), .NCOLS(NCOLS)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .frame_start(frame_start), .x(x), .y(y), .pixel_color(pixel_color),
    .pixel_write(pixel_write), .busy(busy)
  );

  typedef struct { bit pw; int x; int y; int c; bit bsy; } cyc_t;
  typedef struct { logic [DATA_W-1:0] smp; int lo; int hi; } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   m_mem [NCOLS];
  int   m_cnt = 0;
  bit   m_busy = 1'b0;
  int   m_lx = 0, m_ly = 0, m_lc = 0;
  cyc_t exp_q [$];
  int   obs_lo [NCOLS];
  int   obs_hi [NCOLS];
  int   obs_cnt [NCOLS];
  vec_t tbl [NCOLS];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd();
    return DATA_W'($urandom);
  endfunction

  // One clock: apply inputs, advance past the edge, and let the model capture like the spec says.
  task automatic step(input bit sv, input logic [DATA_W-1:0] s, input bit fs, input bit r);
    logic signed [7:0] v;
    sample_valid = sv; sample = s; frame_start = fs; rst = r;
    @(posedge clk); #1;
    v = s[DATA_W-1 -: 8];
    if (r) begin
      m_cnt = 0; m_lx = 0; m_ly = 0; m_lc = 0; m_busy = 1'b0;
    end else if (sv && !m_busy && m_cnt < NCOLS) begin
      m_mem[m_cnt] = int'(v);
      m_cnt++;
    end
    sample_valid = 1'b0; frame_start = 1'b0; rst = 1'b0;
  endtask

  task automatic send_sample(input logic [DATA_W-1:0] s);
    step(1'b1, s, 1'b0, 1'b0);
    if ($urandom_range(0, 3) == 0) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Expected cycle-by-cycle outputs from the cycle after frame_start until busy drops.
  task automatic build_expected(output int nw);
    int prev, cur, lo, hi;
    exp_q.delete();
    nw = 0;
    prev = 0;
    for (int yy = 0; yy < NROWS; yy++)
      for (int xx = 0; xx < NCOLS; xx++) begin
        exp_q.push_back('{1'b1, xx, yy, 0, 1'b1});
        nw++;
      end
    m_lx = NCOLS - 1; m_ly = NROWS - 1; m_lc = 0;
    for (int k = 0; k < NCOLS; k++) begin
      cur = 240 - m_mem[k];
      if (k == 0) prev = cur;
      lo = (prev < cur) ? prev : cur;
      hi = (prev < cur) ? cur : prev;
      repeat (2) exp_q.push_back('{1'b0, m_lx, m_ly, m_lc, 1'b1});
      for (int r = lo; r <= hi; r++) begin
        exp_q.push_back('{1'b1, k, r, 1, 1'b1});
        nw++;
      end
      m_lx = k; m_ly = hi; m_lc = 1;
      prev = cur;
    end
    exp_q.push_back('{1'b0, m_lx, m_ly, m_lc, 1'b0});
  endtask

  task automatic run_frame(input string name, input int abort_at);
    int   nw_exp, nw_act, mism, bad, xi, yi;
    cyc_t e, g, e_bad, g_bad;
    if (m_cnt < NCOLS) begin
      bad = 0;
      step(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
        if (pixel_write !== 1'b0 || busy !== 1'b0) bad++;
        step(1'b0, '0, 1'b0, 1'b0);
      end
      check({name, " skipped-frame active cycles"}, bad, 0);
      return;
    end
    build_expected(nw_exp);
    for (int k = 0; k < NCOLS; k++) begin
      obs_lo[k] = 9999; obs_hi[k] = -1; obs_cnt[k] = 0;
    end
    nw_act = 0;
    mism = -1;
    e_bad = '{1'b0, 0, 0, 0, 1'b0};
    g_bad = e_bad;
    step(1'b0, '0, 1'b1, 1'b0);
    m_busy = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        step(1'b1, rnd(), 1'b0, 1'b1);
        check({name, " pixel_write after rst"}, int'(pixel_write), 0);
        check({name, " busy after rst"}, int'(busy), 0);
        check({name, " x/y/color after rst"}, int'(x) + int'(y) + int'(pixel_color), 0);
        break;
      end
      e = exp_q[i];
      g = '{pixel_write, int'(x), int'(y), int'(pixel_color), busy};
      if (mism < 0 && ($isunknown({pixel_write, x, y, pixel_color, busy}) ||
          g.pw != e.pw || g.x != e.x || g.y != e.y || g.c != e.c || g.bsy != e.bsy)) begin
        mism = i; e_bad = e; g_bad = g;
      end
      if (pixel_write === 1'b1) begin
        nw_act++;
        xi = int'(x); yi = int'(y);
        if (pixel_color === 1'b1 && xi < NCOLS) begin
          obs_cnt[xi]++;
          if (yi < obs_lo[xi]) obs_lo[xi] = yi;
          if (yi > obs_hi[xi]) obs_hi[xi] = yi;
        end
      end
      if (i < exp_q.size() - 1)
        step(1'($urandom_range(0, 1)), rnd(), ($urandom_range(0, 7) == 0), 1'b0);
    end
    checks++;
    if (mism >= 0) begin
      failures++;
      $display("FAIL %s stream idx=%0d got pw=%0d x=%0d y=%0d c=%0d busy=%0d want pw=%0d x=%0d y=%0d c=%0d busy=%0d",
               name, mism, g_bad.pw, g_bad.x, g_bad.y, g_bad.c, g_bad.bsy,
               e_bad.pw, e_bad.x, e_bad.y, e_bad.c, e_bad.bsy);
    end
    if (abort_at < 0) begin
      check({name, " write count"}, nw_act, nw_exp);
      m_busy = 1'b0;
      m_cnt = 0;
    end
  endtask

  initial begin
    // Column samples with hand-derived spans: row = 240 - top byte, span joins previous row.
    tbl[0] = '{16'h0000, 240, 240};
    tbl[1] = '{16'h7FFF, 113, 240};
    tbl[2] = '{16'h8000, 113, 368};
    tbl[3] = '{16'h00FF, 240, 368};
    tbl[4] = '{16'h0100, 239, 240};
    tbl[5] = '{16'hFF00, 239, 241};
    tbl[6] = '{16'h1234, 222, 241};
    tbl[7] = '{16'hF0FF, 222, 256};

    sample_valid = 1'b0; sample = '0; frame_start = 1'b0; rst = 1'b1;
    step(1'b1, 16'h1234, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("reset pixel_write", int'(pixel_write), 0);
    check("reset busy", int'(busy), 0);
    check("reset x", int'(x), 0);
    check("reset y", int'(y), 0);
    check("reset pixel_color", int'(pixel_color), 0);

    for (int i = 0; i < NCOLS; i++) send_sample('0);
    run_frame("zeros", -1);
    for (int k = 0; k < NCOLS; k++) check("zeros row", obs_lo[k] * 1000 + obs_cnt[k], 240001);
    check("zeros busy after", int'(busy), 0);

    for (int i = 0; i < NCOLS; i++) send_sample(tbl[i].smp);
    run_frame("table", -1);
    for (int i = 0; i < NCOLS; i++) begin
      check($sformatf("table col%0d lo", i), obs_lo[i], tbl[i].lo);
      check($sformatf("table col%0d hi", i), obs_hi[i], tbl[i].hi);
      check($sformatf("table col%0d count", i), obs_cnt[i], tbl[i].hi - tbl[i].lo + 1);
    end

    for (int i = 0; i < NCOLS - 1; i++) send_sample((i % 2 == 0) ? 16'h7FFF : 16'h8000);
    run_frame("one-short", -1);
    send_sample(16'h8000);
    run_frame("alternating", -1);
    check("alt col0 count", obs_cnt[0], 1);
    check("alt col0 row", obs_lo[0], 113);
    check("alt col1 count", obs_cnt[1], 256);
    check("alt col1 span", obs_lo[1] * 1000 + obs_hi[1], 113368);

    for (int i = 0; i < NCOLS + 5; i++)
      send_sample({8'(((i * 40) % 256) - 128), 8'($urandom)});
    run_frame("ramp+extra", -1);

    for (int i = 0; i < NCOLS; i++) send_sample(rnd());
    run_frame("abort-clear", 100);
    run_frame("post-abort", -1);

    for (int i = 0; i < NCOLS; i++) send_sample((i % 2 == 0) ? 16'h7FFF : 16'h8000);
    run_frame("abort-draw", NCOLS * NROWS + 3 + 2 + 50);
    run_frame("post-abort2", -1);
    for (int i = 0; i < NCOLS; i++) send_sample(rnd());
    run_frame("refill", -1);

    for (int i = 0; i < NCOLS + 3; i++) send_sample(rnd());
    run_frame("random", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
